// File: rtl/bus_xfer.sv
// Registered two-port bus transfer engine: arbitrate, drive bus_out from a source slot, strobe one destination.
// Optional parity on the driven bus is enabled by defining BUS_XFER_PARITY_EN.
module bus_xfer #(
  parameter int DATA_W     = 16,
  parameter int NUM_SRC    = 16,
  parameter int NUM_DST    = 16,
  parameter int SEL_W      = 4,
  parameter int STARVE_LIM = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      req_a,
  input  logic [SEL_W-1:0]          rd_sel_a,
  input  logic [SEL_W-1:0]          wr_sel_a,
  input  logic                      req_b,
  input  logic [SEL_W-1:0]          rd_sel_b,
  input  logic [SEL_W-1:0]          wr_sel_b,
  output logic                      gnt_a,
  output logic                      gnt_b,
  output logic [DATA_W-1:0]         bus_out,
  output logic [NUM_DST-1:0]        wr_en,
  output logic                      done,
`ifdef BUS_XFER_PARITY_EN
  output logic                      busy,
  output logic                      bus_par,
  output logic                      par_err
`else
  output logic                      busy
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [7:0] LIM     = 8'(STARVE_LIM);

  logic [1:0]         state;
  logic [SEL_W-1:0]   rd_lat;
  logic [SEL_W-1:0]   wr_lat;
  logic [7:0]         starve_cnt;
  logic               arb_en;
  logic               win_a;
  logic               win_b;
  logic [DATA_W-1:0]  src_val;
  logic [NUM_DST-1:0] onehot;

  // Arbitration: B only beats A once A has been favoured STARVE_LIM times in a row.
  always_comb begin
    arb_en = 1'b0;
    win_b  = 1'b0;
    win_a  = 1'b0;
    if (state == S_IDLE || state == S_WRITE) begin
      arb_en = 1'b1;
    end else begin
      arb_en = 1'b0;
    end
    win_b = arb_en && req_b && (!req_a || (starve_cnt == LIM));
    win_a = arb_en && !win_b && req_a;
  end

  // Source mux and destination decode; reserved index 0 and out-of-range selects give zero.
  always_comb begin
    src_val = {DATA_W{1'b0}};
    onehot  = {NUM_DST{1'b0}};
    if ((rd_lat != {SEL_W{1'b0}}) && (int'(rd_lat) < NUM_SRC)) begin
      src_val = src_data[int'(rd_lat)*DATA_W +: DATA_W];
    end else begin
      src_val = {DATA_W{1'b0}};
    end
    if ((wr_lat != {SEL_W{1'b0}}) && (int'(wr_lat) < NUM_DST)) begin
      onehot[int'(wr_lat)] = 1'b1;
    end else begin
      onehot = {NUM_DST{1'b0}};
    end
  end

  // Transfer sequencer: IDLE/WRITE arbitrate, DRIVE loads the bus and queues the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rd_lat  <= {SEL_W{1'b0}};
      wr_lat  <= {SEL_W{1'b0}};
      gnt_a   <= 1'b0;
      gnt_b   <= 1'b0;
      bus_out <= {DATA_W{1'b0}};
      wr_en   <= {NUM_DST{1'b0}};
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      gnt_a <= win_a;
      gnt_b <= win_b;
      wr_en <= {NUM_DST{1'b0}};
      done  <= 1'b0;
      case (state)
        S_IDLE, S_WRITE: begin
          if (win_a || win_b) begin
            rd_lat <= win_b ? rd_sel_b : rd_sel_a;
            wr_lat <= win_b ? wr_sel_b : wr_sel_a;
            state  <= S_DRIVE;
            busy   <= 1'b1;
          end else begin
            state  <= S_IDLE;
            busy   <= 1'b0;
          end
        end
        S_DRIVE: begin
          bus_out <= src_val;
          wr_en   <= onehot;
          done    <= 1'b1;
          state   <= S_WRITE;
          busy    <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Starvation counter: counts A wins while B waits, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 8'd0;
    end else if (win_b || !req_b) begin
      starve_cnt <= 8'd0;
    end else if (win_a && (starve_cnt != LIM)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

`ifdef BUS_XFER_PARITY_EN
  function automatic logic even_par(input logic [DATA_W-1:0] v);
    return ^v;
  endfunction

  // Parity bit tracks bus_out, loaded on the same DRIVE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_par <= 1'b0;
    end else if (state == S_DRIVE) begin
      bus_par <= even_par(src_val);
    end else begin
      bus_par <= bus_par;
    end
  end

  // Integrity check while destinations consume the bus; built only from registered state.
  always_comb begin
    par_err = 1'b0;
    if (state == S_WRITE) begin
      par_err = (even_par(bus_out) != bus_par);
    end else begin
      par_err = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_bus_xfer.sv
// Self-checking bench for bus_xfer: directed literal checks plus randomized traffic against a transaction-level model.
module tb_bus_xfer;
  localparam int DW = 16;
  localparam int NS = 16;
  localparam int ND = 16;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NS*DW-1:0] src_data;
  logic [DW-1:0] src_mem [NS];
  logic          req_a = 1'b0, req_b = 1'b0;
  logic [3:0]    rd_sel_a = 4'd0, wr_sel_a = 4'd0, rd_sel_b = 4'd0, wr_sel_b = 4'd0;
  logic          gnt_a, gnt_b, done, busy;
  logic [DW-1:0] bus_out;
  logic [ND-1:0] wr_en;
`ifdef BUS_XFER_PARITY_EN
  logic          bus_par, par_err;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    src_data = '0;
    for (int k = 0; k < NS; k++) src_data[k*DW +: DW] = src_mem[k];
  end

  bus_xfer dut (
    .clk(clk), .rst(rst), .src_data(src_data),
    .req_a(req_a), .rd_sel_a(rd_sel_a), .wr_sel_a(wr_sel_a),
    .req_b(req_b), .rd_sel_b(rd_sel_b), .wr_sel_b(wr_sel_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .bus_out(bus_out), .wr_en(wr_en),
`ifdef BUS_XFER_PARITY_EN
    .done(done), .busy(busy), .bus_par(bus_par), .par_err(par_err)
`else
    .done(done), .busy(busy)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a granted transfer occupies the next edge (bus load), then the engine is free again.
  logic          e_gnt_a = 1'b0, e_gnt_b = 1'b0, e_done = 1'b0, e_busy = 1'b0;
  logic [DW-1:0] e_bus = '0;
  logic [ND-1:0] e_wr = '0;
  bit            m_xfer_due = 1'b0;
  int            m_rd = 0, m_wr = 0, m_cnt = 0;

  always @(posedge clk) begin
    bit aw, bw;
    aw = 1'b0; bw = 1'b0;
    if (rst) begin
      e_gnt_a = 0; e_gnt_b = 0; e_done = 0; e_busy = 0; e_bus = '0; e_wr = '0;
      m_xfer_due = 0; m_cnt = 0;
    end else begin
      e_gnt_a = 0; e_gnt_b = 0; e_done = 0; e_wr = '0;
      if (m_xfer_due) begin
        m_xfer_due = 0;
        e_bus  = (m_rd >= 1 && m_rd < NS) ? src_mem[m_rd] : '0;
        e_wr   = (m_wr >= 1 && m_wr < ND) ? ND'(1) << m_wr : '0;
        e_done = 1;
        e_busy = 1;
      end else begin
        bw = req_b && (!req_a || m_cnt == LIM);
        aw = !bw && req_a;
        if (aw || bw) begin
          m_rd = bw ? int'(rd_sel_b) : int'(rd_sel_a);
          m_wr = bw ? int'(wr_sel_b) : int'(wr_sel_a);
          e_gnt_a = aw; e_gnt_b = bw;
          m_xfer_due = 1;
          e_busy = 1;
        end else begin
          e_busy = 0;
        end
      end
      if (bw || !req_b) m_cnt = 0;
      else if (aw) m_cnt = (m_cnt + 1 > LIM) ? LIM : m_cnt + 1;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("gnt_a", 32'(gnt_a), 32'(e_gnt_a));
      chk("gnt_b", 32'(gnt_b), 32'(e_gnt_b));
      chk("bus_out", 32'(bus_out), 32'(e_bus));
      chk("wr_en", 32'(wr_en), 32'(e_wr));
      chk("done", 32'(done), 32'(e_done));
      chk("busy", 32'(busy), 32'(e_busy));
`ifdef BUS_XFER_PARITY_EN
      chk("bus_par", 32'(bus_par), 32'(^e_bus));
      chk("par_err", 32'(par_err), 32'd0);
`endif
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    for (int i = 0; i < NS; i++) src_mem[i] = 16'(i * 16'h0101);
    src_mem[7] = 16'h1234;
    src_mem[2] = 16'h0007;
    // Reset held with a pending A request: no grant, outputs cleared.
    req_a = 1'b1; rd_sel_a = 4'd7; wr_sel_a = 4'd3;
    step(); chk_on = 1'b1;
    chk("rst_gnt0", 32'(gnt_a), 32'd0);
    step();
    chk("rst_gnt1", 32'(gnt_a), 32'd0);
    chk("rst_bus", 32'(bus_out), 32'd0);
    chk("rst_wr", 32'(wr_en), 32'd0);
    rst = 1'b0;
    // Single A transfer from slot 7 to destination 3.
    step();
    chk("a_gnt", 32'(gnt_a), 32'd1);
    req_a = 1'b0; rd_sel_a = 4'd9; wr_sel_a = 4'd9;
    step();
    chk("a_bus", 32'(bus_out), 32'h1234);
    chk("a_wr", 32'(wr_en), 32'h0008);
    chk("a_done", 32'(done), 32'd1);
    // Reserved source 0 to destination 5.
    req_a = 1'b1; rd_sel_a = 4'd0; wr_sel_a = 4'd5;
    step();
    chk("r0_gnt", 32'(gnt_a), 32'd1);
    req_a = 1'b0;
    step();
    chk("r0_bus", 32'(bus_out), 32'd0);
    chk("r0_wr", 32'(wr_en), 32'h0020);
    // Reserved destination 0: strobe suppressed, done still pulses.
    req_a = 1'b1; rd_sel_a = 4'd7; wr_sel_a = 4'd0;
    step(); req_a = 1'b0;
    step();
    chk("w0_wr", 32'(wr_en), 32'd0);
    chk("w0_done", 32'(done), 32'd1);
    chk("w0_bus", 32'(bus_out), 32'h1234);
`ifdef BUS_XFER_PARITY_EN
    req_a = 1'b1; rd_sel_a = 4'd2; wr_sel_a = 4'd1;
    step(); req_a = 1'b0;
    step();
    chk("par_bit", 32'(bus_par), 32'd1);
    chk("par_err", 32'(par_err), 32'd0);
`endif
    step(); step();
    // Both requesters saturated: every fifth grant goes to B.
    req_a = 1'b1; rd_sel_a = 4'd1; wr_sel_a = 4'd1;
    req_b = 1'b1; rd_sel_b = 4'd2; wr_sel_b = 4'd2;
    k = 0;
    for (int c = 0; c < 60 && k < 10; c++) begin
      step();
      if (gnt_a || gnt_b) begin
        chk($sformatf("starve_g%0d", k), 32'(gnt_b), (k % 5 == 4) ? 32'd1 : 32'd0);
        k++;
      end
    end
    chk("starve_count", 32'(k), 32'd10);
    req_a = 1'b0; req_b = 1'b0;
    step(); step(); step();
    // Reset during DRIVE aborts the transfer.
    req_a = 1'b1; rd_sel_a = 4'd7; wr_sel_a = 4'd3;
    step();
    chk("mid_gnt", 32'(gnt_a), 32'd1);
    rst = 1'b1; req_a = 1'b0;
    step();
    chk("mid_wr", 32'(wr_en), 32'd0);
    chk("mid_bus", 32'(bus_out), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();
    chk("mid_wr2", 32'(wr_en), 32'd0);
    // Randomized traffic; requests are held until granted, selects churn otherwise.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 249) == 0) rst = 1'b1;
      if (req_a && gnt_a) req_a = 1'b0;
      else if (!req_a && $urandom_range(0, 2) == 0) req_a = 1'b1;
      if (req_b && gnt_b) req_b = 1'b0;
      else if (!req_b && $urandom_range(0, 3) == 0) req_b = 1'b1;
      if (!req_a || gnt_a) begin rd_sel_a = 4'($urandom); wr_sel_a = 4'($urandom); end
      if (!req_b || gnt_b) begin rd_sel_b = 4'($urandom); wr_sel_b = 4'($urandom); end
      if ($urandom_range(0, 3) == 0) src_mem[$urandom_range(0, NS - 1)] = 16'($urandom);
    end
    req_a = 1'b0; req_b = 1'b0; rst = 1'b0;
    step(); step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
